fir_tap_sequencer: RTL and testbench

- Control block for the shared 128-tap match-filter MAC datapath: turns each sample strobe into a write, clear, tap-sweep, drain and result-valid sequence.
- Drives the datapath's sample write slot (offset) and tap/coefficient index (index), the accumulator clear, and MAC enable.
- Flags result-valid to downstream peak/heart-rate logic.
- Detects strobes that arrive while a pass is running, drops them and counts them.

---
 rtl/fir_tap_sequencer.sv | 152 +++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
// Control sequencer for a shared TAPS-tap match-filter MAC datapath. Each
// accepted sample strobe runs one pass: LOAD (write sample, clear accumulator),
// RUN (one MAC per tap), DRAIN (flush datapath pipeline), DONE (result valid,
// advance the circular-buffer write slot). Strobes that arrive mid-pass are
// dropped, flagged and counted.
//
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   ready        new-sample strobe (one cycle)
//   enable       gates ready; a running pass always completes
//   overrun_clr  clears the sticky overrun flag (a same-cycle new drop wins)
//   sample_we    write input sample into slot offset (LOAD)
//   acc_clear    zero the accumulator (LOAD)
//   mac_en       accumulate product for current index (RUN)
//   index        tap index / coefficient ROM address
//   offset       circular-buffer slot of the newest sample
//   y_valid      one-cycle pulse, datapath output final (DONE)
//   busy         high in every state except IDLE
//   overrun      sticky: a ready strobe was dropped
//   drop_count   saturating count of dropped strobes
module fir_tap_sequencer #(
  parameter int TAPS  = 128,
  parameter int IDX_W = 7,
  parameter int PIPE  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ready,
  input  logic             enable,
  input  logic             overrun_clr,
  output logic             sample_we,
  output logic             acc_clear,
  output logic             mac_en,
  output logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] offset,
  output logic             y_valid,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       drop_count
);

  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] offset_q, offset_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       drop_q, drop_d;
  logic             sample_we_q, sample_we_d;
  logic             acc_clear_q, acc_clear_d;
  logic             mac_en_q, mac_en_d;
  logic             y_valid_q, y_valid_d;
  logic             busy_q, busy_d;
  logic             drop_strobe;

  always_comb begin
    state_d     = state_q;
    index_d     = '0;
    offset_d    = offset_q;
    drain_d     = '0;
    drop_strobe = ready && enable && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (ready && enable) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (index_q == IDX_W'(TAPS - 1)) begin
          state_d = (PIPE == 0) ? DONE : DRAIN;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(PIPE - 1)) state_d = DONE;
        else                          drain_d = drain_q + 1'b1;
      end
      DONE: begin
        offset_d = (offset_q == IDX_W'(TAPS - 1)) ? '0 : offset_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    if (drop_strobe)      overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;
    else                  overrun_d = overrun_q;

    drop_d = (drop_strobe && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    // Decoded from the next state so each flop is high exactly in its state.
    sample_we_d = (state_d == LOAD);
    acc_clear_d = (state_d == LOAD);
    mac_en_d    = (state_d == RUN);
    y_valid_d   = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      offset_q    <= '0;
      drain_q     <= '0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
      sample_we_q <= 1'b0;
      acc_clear_q <= 1'b0;
      mac_en_q    <= 1'b0;
      y_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      offset_q    <= offset_d;
      drain_q     <= drain_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
      sample_we_q <= sample_we_d;
      acc_clear_q <= acc_clear_d;
      mac_en_q    <= mac_en_d;
      y_valid_q   <= y_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sample_we  = sample_we_q;
  assign acc_clear  = acc_clear_q;
  assign mac_en     = mac_en_q;
  assign index      = index_q;
  assign offset     = offset_q;
  assign y_valid    = y_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Testbench for fir_tap_sequencer with default parameters (128 taps, PIPE=2).
// Cycle c is the clock period after the c-th rising edge; a strobe driven in
// cycle 0 is sampled at the edge that starts cycle 1.
module tb_fir_tap_sequencer;

  localparam int TAPS  = 128;
  localparam int IDX_W = 7;
  localparam int PIPE  = 2;

  logic             clock;
  logic             reset;
  logic             ready;
  logic             enable;
  logic             overrun_clr;
  logic             sample_we;
  logic             acc_clear;
  logic             mac_en;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] offset;
  logic             y_valid;
  logic             busy;
  logic             overrun;
  logic [7:0]       drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  fir_tap_sequencer #(
    .TAPS (TAPS),
    .IDX_W(IDX_W),
    .PIPE (PIPE)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .enable     (enable),
    .overrun_clr(overrun_clr),
    .sample_we  (sample_we),
    .acc_clear  (acc_clear),
    .mac_en     (mac_en),
    .index      (index),
    .offset     (offset),
    .y_valid    (y_valid),
    .busy       (busy),
    .overrun    (overrun),
    .drop_count (drop_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One record: inputs applied for one cycle (enable persists), then adv
  // cycles elapse, then all outputs are compared.
  typedef struct {
    logic rdy;
    logic en;
    logic clr;
    int   adv;
    int   sw;
    int   ac;
    int   mac;
    int   idx;
    int   off;
    int   yv;
    int   bsy;
    int   ovr;
    int   drop;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    ready       = 1'b0;
    overrun_clr = 1'b0;
    enable      = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  // Advance until busy drops, bounded; counts y_valid pulses seen on the way.
  task automatic wait_idle(input string name, input int budget, output int yv_seen);
    int n;
    n       = 0;
    yv_seen = 0;
    while (busy && n < budget) begin
      if (y_valid) yv_seen++;
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    int yv_total;
    int yv_seen;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1,   1, 1, 0, 0,   0, 0, 1, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1,   0, 0, 1, 0,   0, 0, 1, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1,   0, 0, 1, 1,   0, 0, 1, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 126, 0, 0, 1, 127, 0, 0, 1, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1,   0, 0, 0, 0,   0, 0, 1, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1,   0, 0, 0, 0,   0, 0, 1, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1,   0, 0, 0, 0,   0, 1, 1, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1,   0, 0, 0, 0,   1, 0, 0, 0, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1,   0, 0, 0, 0,   1, 0, 0, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 5,   0, 0, 0, 0,   1, 0, 0, 0, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1,   1, 1, 0, 0,   1, 0, 1, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 9,   0, 0, 1, 8,   1, 0, 1, 0, 0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1,   0, 0, 1, 9,   1, 0, 1, 0, 0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1,   0, 0, 1, 10,  1, 0, 1, 0, 0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 120, 0, 0, 0, 0,   1, 1, 1, 0, 0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1,   0, 0, 0, 0,   2, 0, 0, 0, 0};

    // Reset state
    do_reset();
    chk("rst sample_we", sample_we, 0);
    chk("rst acc_clear", acc_clear, 0);
    chk("rst mac_en", mac_en, 0);
    chk("rst index", index, 0);
    chk("rst offset", offset, 0);
    chk("rst y_valid", y_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    chk("rst drop_count", drop_count, 0);

    // Single pass, enable gating in IDLE, enable dropped mid-pass
    for (int i = 0; i < 16; i++) begin
      ready       = vecs[i].rdy;
      enable      = vecs[i].en;
      overrun_clr = vecs[i].clr;
      tick();
      ready       = 1'b0;
      overrun_clr = 1'b0;
      ticks(vecs[i].adv - 1);
      chk($sformatf("vec%0d sample_we", i), sample_we, vecs[i].sw);
      chk($sformatf("vec%0d acc_clear", i), acc_clear, vecs[i].ac);
      chk($sformatf("vec%0d mac_en", i), mac_en, vecs[i].mac);
      chk($sformatf("vec%0d index", i), index, vecs[i].idx);
      chk($sformatf("vec%0d offset", i), offset, vecs[i].off);
      chk($sformatf("vec%0d y_valid", i), y_valid, vecs[i].yv);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
      chk($sformatf("vec%0d overrun", i), overrun, vecs[i].ovr);
      chk($sformatf("vec%0d drop_count", i), drop_count, vecs[i].drop);
    end

    // Wrap: 128 back-to-back passes
    do_reset();
    yv_total = 0;
    for (int p = 0; p < TAPS; p++) begin
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk($sformatf("wrap pass%0d offset", p), offset, p);
      wait_idle($sformatf("wrap pass%0d ends", p), 200, yv_seen);
      yv_total += yv_seen;
    end
    chk("wrap offset after", offset, 0);
    chk("wrap y_valid count", yv_total, 128);

    // Overrun: strobes at cycles 0, 50 and 132
    do_reset();
    ready = 1'b1; tick(); ready = 1'b0;
    ticks(49);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovr c51 overrun", overrun, 1);
    chk("ovr c51 drop_count", drop_count, 1);
    chk("ovr c51 index", index, 49);
    ticks(81);
    chk("ovr c132 y_valid", y_valid, 1);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovr c133 busy", busy, 0);
    chk("ovr c133 overrun", overrun, 1);
    chk("ovr c133 drop_count", drop_count, 2);
    chk("ovr c133 offset", offset, 1);
    ticks(3);
    chk("ovr no second pass", busy, 0);
    ready = 1'b1; tick(); ready = 1'b0;
    ticks(9);
    ready = 1'b1; overrun_clr = 1'b1; tick(); ready = 1'b0; overrun_clr = 1'b0;
    chk("ovr set wins overrun", overrun, 1);
    chk("ovr set wins drop_count", drop_count, 3);
    overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
    chk("ovr clr overrun", overrun, 0);
    chk("ovr clr drop_count", drop_count, 3);
    chk("ovr clr still running", mac_en, 1);
    wait_idle("ovr pass ends", 200, yv_seen);
    chk("ovr pass y_valid", yv_seen, 1);

    // Saturation: ready held high across several passes
    do_reset();
    ready = 1'b1;
    ticks(101);
    chk("sat drop_count 100", drop_count, 100);
    ticks(300);
    chk("sat drop_count 255", drop_count, 255);
    ticks(50);
    chk("sat drop_count hold", drop_count, 255);
    chk("sat overrun", overrun, 1);
    ready = 1'b0;
    wait_idle("sat ends", 200, yv_seen);

    // Reset at cycle 60 of a pass
    ready = 1'b1; tick(); ready = 1'b0;
    ticks(59);
    chk("rmid running", mac_en, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rmid busy", busy, 0);
    chk("rmid mac_en", mac_en, 0);
    chk("rmid index", index, 0);
    chk("rmid offset", offset, 0);
    chk("rmid y_valid", y_valid, 0);
    chk("rmid overrun", overrun, 0);
    chk("rmid drop_count", drop_count, 0);
    yv_seen = 0;
    for (int k = 0; k < 140; k++) begin
      if (y_valid || busy) yv_seen++;
      tick();
    end
    chk("rmid no y_valid", yv_seen, 0);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("rmid next load", sample_we, 1);
    ticks(130);
    chk("rmid next c131 y_valid", y_valid, 0);
    tick();
    chk("rmid next c132 y_valid", y_valid, 1);
    tick();
    chk("rmid next c133 busy", busy, 0);
    chk("rmid next c133 offset", offset, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
